// File: rtl/exu_inst_queue.sv
//============================================================================
// Module      : exu_inst_queue
// Description : Four-lane IFU->EXU instruction receiver; compacts accepted
//               lanes into a circular FIFO and issues one per cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module exu_inst_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_instA_valid,
    output logic              ifu_instA_allowIn,
    input  logic [DATA_W-1:0] ifu_instA_data,
    input  logic              ifu_instB_valid,
    output logic              ifu_instB_allowIn,
    input  logic [DATA_W-1:0] ifu_instB_data,
    input  logic              ifu_instC_valid,
    output logic              ifu_instC_allowIn,
    input  logic [DATA_W-1:0] ifu_instC_data,
    input  logic              ifu_instD_valid,
    output logic              ifu_instD_allowIn,
    input  logic [DATA_W-1:0] ifu_instD_data,
    input  logic              exu_flush,
    output logic              exu_inst_valid,
    input  logic              exu_inst_ready,
    output logic [DATA_W-1:0] exu_inst_data,
    output logic [CNT_W-1:0]  iq_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [CNT_W-1:0]   w_space;
    logic [3:0]         w_valid;
    logic [3:0]         w_allow;
    logic [3:0]         w_xfer;
    logic [2:0]         w_nEnq;
    logic [2:0]         w_ofs [4];
    logic [DATA_W-1:0]  w_data [4];
    logic               w_deq;

    assign w_valid   = {ifu_instD_valid, ifu_instC_valid, ifu_instB_valid, ifu_instA_valid};
    assign w_data[0] = ifu_instA_data;
    assign w_data[1] = ifu_instB_data;
    assign w_data[2] = ifu_instC_data;
    assign w_data[3] = ifu_instD_data;

    // allowIn looks only at registered occupancy so no path exists from any valid
    always_comb begin
        w_space = CNT_W'(DEPTH) - r_count;
        w_nEnq  = 3'd0;
        for (int k = 0; k < 4; k++) begin
            w_allow[k] = rst && !exu_flush && (w_space >= CNT_W'(k + 1));
            w_xfer[k]  = w_valid[k] && w_allow[k];
            w_ofs[k]   = w_nEnq;
            w_nEnq     = w_nEnq + {2'b00, w_xfer[k]};
        end
    end

    assign ifu_instA_allowIn = w_allow[0];
    assign ifu_instB_allowIn = w_allow[1];
    assign ifu_instC_allowIn = w_allow[2];
    assign ifu_instD_allowIn = w_allow[3];

    assign exu_inst_valid = (r_count != '0);
    assign exu_inst_data  = r_mem[r_rdPtr];
    assign iq_count       = r_count;
    assign w_deq          = exu_inst_valid && exu_inst_ready && !exu_flush;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_xfer[k]) begin
                r_mem[r_wrPtr + c_PTR_W'(w_ofs[k])] <= w_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (exu_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + c_PTR_W'(w_nEnq);
            r_rdPtr <= r_rdPtr + c_PTR_W'(w_deq);
            r_count <= r_count + CNT_W'(w_nEnq) - CNT_W'(w_deq);
        end
    end

`ifndef SYNTHESIS
    a_countBound: assert property (@(posedge clk) disable iff (!rst)
        r_count <= CNT_W'(DEPTH));
    a_noDeqEmpty: assert property (@(posedge clk) disable iff (!rst)
        !(w_deq && (r_count == '0)));
    a_holdStable: assert property (@(posedge clk) disable iff (!rst)
        (exu_inst_valid && !exu_inst_ready && !exu_flush) |=> $stable(exu_inst_data));
`endif

endmodule

`default_nettype wire

// File: tb/tb_exu_inst_queue.sv
//============================================================================
// Module      : tb_exu_inst_queue
// Description : Randomized scoreboard bench for exu_inst_queue.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_exu_inst_queue;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        vld = 4'b0;
    logic [DATA_W-1:0] dat [4];
    logic              rdy = 1'b0;
    logic              fl  = 1'b0;
    logic              aA, aB, aC, aD;
    logic              exVal;
    logic [DATA_W-1:0] exData;
    logic [CNT_W-1:0]  cnt;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] expQ [$];
    logic [3:0]        drvAllow = 4'b0;
    bit                done = 1'b0;

    exu_inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .ifu_instA_valid   (vld[0]),
        .ifu_instA_allowIn (aA),
        .ifu_instA_data    (dat[0]),
        .ifu_instB_valid   (vld[1]),
        .ifu_instB_allowIn (aB),
        .ifu_instB_data    (dat[1]),
        .ifu_instC_valid   (vld[2]),
        .ifu_instC_allowIn (aC),
        .ifu_instC_data    (dat[2]),
        .ifu_instD_valid   (vld[3]),
        .ifu_instD_allowIn (aD),
        .ifu_instD_data    (dat[3]),
        .exu_flush         (fl),
        .exu_inst_valid    (exVal),
        .exu_inst_ready    (rdy),
        .exu_inst_data     (exData),
        .iq_count          (cnt)
    );

    always #5 clk = ~clk;

    // Lane k may transfer when at least k+1 slots are free
    function automatic logic [3:0] modelAllow(int occ, logic r, logic f);
        logic [3:0] a;
        for (int k = 0; k < 4; k++) a[k] = r && !f && ((DEPTH - occ) >= (k + 1));
        return a;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic rd, input logic f,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
        @(negedge clk);
        rst = r; vld = v; rdy = rd; fl = f;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
        if (!r) expQ.delete();
        drvAllow = modelAllow(expQ.size(), r, f);
        #4;
        if (r && f) expQ.delete();
        else if (r) begin
            for (int k = 0; k < 4; k++)
                if (v[k] && drvAllow[k]) expQ.push_back(dat[k]);
        end
    endtask

    task automatic idle(input logic rd);
        step(1'b1, 4'b0, rd, 1'b0, '0, '0, '0, '0);
    endtask

    // Monitor: compares DUT state with the model just before each rising edge
    initial begin
        int n;
        while (!done) begin
            @(negedge clk);
            #3;
            n = expQ.size();
            chk("allowIn", {28'b0, aD, aC, aB, aA}, {28'b0, drvAllow});
            chk("iq_count", {27'b0, cnt}, n);
            if (!fl) chk("valid", {31'b0, exVal}, {31'b0, n != 0});
            if (rst && !fl && exVal === 1'b1 && rdy) begin
                if (n == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_empty: got data 0x%0h expected no dequeue at %0t", exData, $time);
                end else begin
                    chk("data", exData, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int rdPct;
        dat[0] = '0; dat[1] = '0; dat[2] = '0; dat[3] = '0;

        // Reset held with all lanes valid, then release
        repeat (3) step(1'b0, 4'hF, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4);
        idle(1'b0);

        // Four-lane burst drained with ready high
        step(1'b1, 4'hF, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        repeat (5) idle(1'b1);

        // Fill to full, then one dequeue frees lane A only
        repeat (4) step(1'b1, 4'hF, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
        step(1'b1, 4'hF, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
        step(1'b1, 4'hF, 1'b0, 1'b0, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
        repeat (20) idle(1'b1);

        // Move write pointer to 14, then compacted write across the wrap
        step(1'b0, 4'h0, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (3) step(1'b1, 4'hF, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
        step(1'b1, 4'h3, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
        repeat (16) idle(1'b1);
        step(1'b1, 4'b1101, 1'b0, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
        repeat (5) idle(1'b1);

        // Flush with 9 queued and a concurrent 4-lane offer
        repeat (2) step(1'b1, 4'hF, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
        step(1'b1, 4'h1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
        step(1'b1, 4'hF, 1'b1, 1'b1, 32'h51, 32'h52, 32'h53, 32'h54);
        repeat (2) idle(1'b1);

        // Random traffic with phased ready pressure, rare flushes and resets
        rdPct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) rdPct = (c / 500) % 3 == 0 ? 10 : ((c / 500) % 3 == 1 ? 50 : 90);
            step($urandom_range(0, 999) != 0, 4'($urandom), $urandom_range(0, 99) < rdPct,
                 $urandom_range(0, 99) < 2, $urandom, $urandom, $urandom, $urandom);
        end
        repeat (20) idle(1'b1);

        done = 1'b1;
        @(negedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
